// File: rtl/selector_jugada_if.sv
// rtl/selector_jugada_if.sv - move-entry signals between the turn controller, buttons, board and selector
`timescale 1ns/1ps
interface selector_jugada_if;
  logic        turno_inicio;
  logic        btn_arriba;
  logic        btn_abajo;
  logic        btn_izq;
  logic        btn_der;
  logic        btn_confirmar;
  logic [15:0] ocupadas;
  logic [3:0]  posicion;
  logic        habilitar;
  logic        esperando;
  logic        timeout_flag;
  logic        tablero_lleno;

  modport master (
    output turno_inicio, btn_arriba, btn_abajo, btn_izq, btn_der, btn_confirmar, ocupadas,
    input  posicion, habilitar, esperando, timeout_flag, tablero_lleno
  );

  modport slave (
    input  turno_inicio, btn_arriba, btn_abajo, btn_izq, btn_der, btn_confirmar, ocupadas,
    output posicion, habilitar, esperando, timeout_flag, tablero_lleno
  );
endinterface

// File: rtl/selector_jugada.sv
// rtl/selector_jugada.sv - cursor/confirm move selector for the 4x4 board with timeout auto-pick
`timescale 1ns/1ps
module selector_jugada #(
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int CNT_W          = 29
) (
  input logic              clk,
  input logic              rst,
  selector_jugada_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SELECT, SEARCH, COMMIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(15);

  state_t           state, state_nxt;
  logic [3:0]       pos, pos_nxt, pos_inc;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       btn_now, btn_prev, btn_edge;
  logic             hab, esp, tflag, lleno;

  // bit order doubles as action priority: confirmar, arriba, abajo, izq, der
  assign btn_now  = {bus.btn_confirmar, bus.btn_arriba, bus.btn_abajo, bus.btn_izq, bus.btn_der};
  assign btn_edge = btn_now & ~btn_prev;
  assign pos_inc  = pos + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pos      <= 4'd0;
      cnt      <= '0;
      btn_prev <= 5'd0;
    end else begin
      state    <= state_nxt;
      pos      <= pos_nxt;
      cnt      <= cnt_nxt;
      btn_prev <= btn_now;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    cnt_nxt   = cnt;
    hab       = 1'b0;
    esp       = 1'b0;
    tflag     = 1'b0;
    lleno     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.turno_inicio) begin
          state_nxt = SELECT;
          pos_nxt   = 4'd0;
          cnt_nxt   = '0;
        end
      end
      SELECT: begin
        esp     = 1'b1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          // timeout preempts any button activity this cycle
          tflag     = 1'b1;
          state_nxt = SEARCH;
          cnt_nxt   = '0;
        end else if (btn_edge[4]) begin
          if (!bus.ocupadas[pos]) state_nxt = COMMIT;
        end else if (btn_edge[3]) begin
          pos_nxt = {pos[3:2] - 2'd1, pos[1:0]};
        end else if (btn_edge[2]) begin
          pos_nxt = {pos[3:2] + 2'd1, pos[1:0]};
        end else if (btn_edge[1]) begin
          pos_nxt = {pos[3:2], pos[1:0] - 2'd1};
        end else if (btn_edge[0]) begin
          pos_nxt = {pos[3:2], pos[1:0] + 2'd1};
        end
      end
      SEARCH: begin
        // cnt reused as the count of cells already scanned
        pos_nxt = pos_inc;
        cnt_nxt = cnt + CNT_W'(1);
        if (!bus.ocupadas[pos_inc]) begin
          state_nxt = COMMIT;
        end else if (cnt == SCAN_LAST) begin
          lleno     = 1'b1;
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
        hab       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.posicion      = pos;
  assign bus.habilitar     = hab;
  assign bus.esperando     = esp;
  assign bus.timeout_flag  = tflag;
  assign bus.tablero_lleno = lleno;

endmodule
